// File: rtl/float_mul_seq_if.sv
// float_mul_seq_if: req/ack handshake bundle for the sequential float multiplier
interface float_mul_seq_if #(
  parameter int FLOAT_WIDTH = 32
);
  logic                   req;
  logic [FLOAT_WIDTH-1:0] a;
  logic [FLOAT_WIDTH-1:0] b;
  logic [FLOAT_WIDTH-1:0] out;
  logic                   ack;
  logic                   busy;
  modport master(output req, a, b, input out, ack, busy);
  modport slave(input req, a, b, output out, ack, busy);
endinterface

// File: rtl/float_mul_seq.sv
// float_mul_seq: multi-cycle shift-add floating-point multiplier with RNE rounding
module float_mul_seq #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANT_WIDTH     = 23,
  parameter int BIAS           = 2**(EXP_WIDTH-1)-1,
  parameter int BITS_PER_CYCLE = 1,
  parameter int FLOAT_WIDTH    = 1+EXP_WIDTH+MANT_WIDTH
)(
  input logic           clk,
  input logic           rst,
  float_mul_seq_if.slave bus
);
  localparam int W   = MANT_WIDTH + 1;
  localparam int P   = 2 * W;
  localparam int K   = W / BITS_PER_CYCLE;
  localparam int CW  = $clog2(K + 1);
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] EMAX = EW2'(2**EXP_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;
  state_t state, nxt;
  logic                  sgn, bypass;
  logic [EXP_WIDTH-1:0]  ea, eb, in_ea, in_eb;
  logic [MANT_WIDTH-1:0] fa, fb, in_fa, in_fb;
  logic [P-1:0]          mcand, acc, pp, n;
  logic [W-1:0]          mplier;
  logic [CW-1:0]         cnt;
  logic                  special_in;
  logic                  hi, guard, sticky, rnd, carry;
  logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [MANT_WIDTH-1:0] mant, mr;
  logic signed [EW2-1:0] e;
  logic [FLOAT_WIDTH-1:0] qnan, inf_r, zero_r, spec, res;
  assign in_ea = bus.a[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign in_eb = bus.b[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign in_fa = bus.a[MANT_WIDTH-1:0];
  assign in_fb = bus.b[MANT_WIDTH-1:0];
  // zero/subnormal (exp 0) and inf/NaN (exp all ones) skip the multiply
  assign special_in = (in_ea == '0) || (&in_ea) || (in_eb == '0) || (&in_eb);
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  // next-state: IDLE accepts, MUL runs K steps, NORM emits one result
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (bus.req ? (special_in ? NORM : MUL) : IDLE) :
          state == MUL  ? (cnt == CW'(K-1) ? NORM : MUL) : IDLE;
  end
  // partial product, normalisation, rounding, range and special-case result
  always_comb begin
    pp     = mcand * P'(mplier[BITS_PER_CYCLE-1:0]);
    hi     = acc[P-1];
    n      = hi ? acc : acc << 1;
    mant   = n[P-2 -: MANT_WIDTH];
    guard  = n[P-2-MANT_WIDTH];
    sticky = |n[P-3-MANT_WIDTH:0];
    rnd    = guard & (sticky | mant[0]);
    {carry, mr} = {1'b0, mant} + (MANT_WIDTH+1)'(rnd);
    e      = EW2'(ea) + EW2'(eb) - EW2'(BIAS) + EW2'(hi) + EW2'(carry);
    nan_a  = (&ea) & (|fa);
    nan_b  = (&eb) & (|fb);
    inf_a  = (&ea) & ~(|fa);
    inf_b  = (&eb) & ~(|fb);
    zero_a = ea == '0;
    zero_b = eb == '0;
    qnan   = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    inf_r  = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    zero_r = {sgn, {(FLOAT_WIDTH-1){1'b0}}};
    spec   = (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) ? qnan :
             (inf_a | inf_b) ? inf_r : zero_r;
    res    = bypass ? spec :
             e >= EMAX ? inf_r :
             (e[EW2-1] || e == '0) ? zero_r : {sgn, e[EXP_WIDTH-1:0], mr};
  end
  // operand capture, shift-add accumulation and result/handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn      <= 1'b0;
      bypass   <= 1'b0;
      ea       <= '0;
      eb       <= '0;
      fa       <= '0;
      fb       <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      bus.out  <= '0;
      bus.ack  <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      if (state == IDLE && bus.req) begin
        sgn      <= bus.a[FLOAT_WIDTH-1] ^ bus.b[FLOAT_WIDTH-1];
        ea       <= in_ea;
        eb       <= in_eb;
        fa       <= in_fa;
        fb       <= in_fb;
        bypass   <= special_in;
        mcand    <= P'({1'b1, in_fa});
        mplier   <= {1'b1, in_fb};
        acc      <= '0;
        cnt      <= '0;
        bus.busy <= 1'b1;
      end
      if (state == MUL) begin
        acc    <= acc + pp;
        mcand  <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt    <= cnt + 1'b1;
      end
      if (state == NORM) begin
        bus.out  <= res;
        bus.ack  <= 1'b1;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule
